// File: rtl/gpsdo_pkg.sv
// gpsdo_pkg
//   Shared constants, FSM state type and saturation helpers for the GPSDO
//   phase loop filter and its PWM output stage.
//   PERIOD : sys clocks per second (10 MHz)
//   CENTER : mid-scale OCXO tuning duty
//   state_t: loop filter sequencing states
//   sat32  : clamp a 33-bit signed sum to +/-(2^31-1)
//   clamp16: clamp a 42-bit signed value to the unsigned range 0..65535
package gpsdo_pkg;

    localparam int PERIOD = 10_000_000;
    localparam int CENTER = 32768;

    typedef enum logic [1:0] {
        S_ACC = 2'd0,
        S_AVG = 2'd1,
        S_INT = 2'd2,
        S_OUT = 2'd3
    } state_t;

    localparam logic signed [32:0] SAT32_HI = 33'sd2147483647;
    localparam logic signed [32:0] SAT32_LO = -33'sd2147483647;

    // Symmetric clamp: the most negative code -2^31 is never produced.
    function automatic logic signed [31:0] sat32(input logic signed [32:0] x);
        logic signed [31:0] r;
        if (x > SAT32_HI)
            r = SAT32_HI[31:0];
        else if (x < SAT32_LO)
            r = SAT32_LO[31:0];
        else
            r = x[31:0];
        return r;
    endfunction

    function automatic logic [15:0] clamp16(input logic signed [41:0] x);
        logic [15:0] r;
        if (x < 42'sd0)
            r = 16'h0000;
        else if (x > 42'sd65535)
            r = 16'hFFFF;
        else
            r = x[15:0];
        return r;
    endfunction

endpackage

// File: rtl/phase_loop_filter_pwm_gen.sv
// pwm_gen
//   Drives the OCXO tuning PWM pin. A free-running 16-bit counter sets a
//   65536-clock period; the duty is latched into a shadow register only on
//   the wrap cycle so a duty change never produces a runt pulse.
//   CLK_Sys : system clock
//   CLK_Rst : synchronous active-low reset
//   duty    : requested duty (high clocks per 65536)
//   pwm_out : registered PWM pin, high while cnt < shadow
module pwm_gen #(
    parameter logic [15:0] RESET_DUTY = 16'd32768
) (
    input  logic        CLK_Sys,
    input  logic        CLK_Rst,
    input  logic [15:0] duty,
    output logic        pwm_out
);

    logic [15:0] cnt;
    logic [15:0] shadow;

    always_ff @(posedge CLK_Sys) begin
        if (!CLK_Rst) begin
            cnt     <= 16'd0;
            shadow  <= RESET_DUTY;
            pwm_out <= 1'b0;
        end else begin
            cnt     <= cnt + 16'd1;
            pwm_out <= (cnt < shadow);
            if (cnt == 16'hFFFF)
                shadow <= duty;
        end
    end

endmodule

// File: rtl/phase_loop_filter.sv
// phase_loop_filter
//   Converts one 1PPS phase-count sample per second into a signed phase
//   error, averages 2^AVG_SHIFT samples and runs a saturating PI controller
//   that sets the 16-bit OCXO tuning duty. The duty also drives the PWM pin.
//   CLK_Sys     : 10 MHz system clock
//   CLK_Rst     : synchronous active-low reset
//   GPS_Exist   : 1 = GPS present, 0 = holdover (samples ignored)
//   phase_valid : one-cycle strobe qualifying phase_cnt
//   phase_cnt   : clocks from GPS 1PPS edge to local 1PPS edge
//   PWM_Duty    : current tuning duty
//   duty_valid  : one-cycle pulse when PWM_Duty is updated
//   pwm_out     : PWM pin
//
//   state | meaning
//   S_ACC | accept samples, accumulate error sum until 2^AVG_SHIFT taken
//   S_AVG | average = sum >>> AVG_SHIFT, clear accumulator
//   S_INT | integrator += average, saturating
//   S_OUT | PI output -> PWM_Duty, pulse duty_valid
module phase_loop_filter #(
    parameter int                 PERIOD    = gpsdo_pkg::PERIOD,
    parameter int                 CENTER    = gpsdo_pkg::CENTER,
    parameter int                 AVG_SHIFT = 2,
    parameter logic signed [7:0]  KP        = 8'sd16,
    parameter int                 KI_SHIFT  = 4
) (
    input  logic        CLK_Sys,
    input  logic        CLK_Rst,
    input  logic        GPS_Exist,
    input  logic        phase_valid,
    input  logic [23:0] phase_cnt,
    output logic [15:0] PWM_Duty,
    output logic        duty_valid,
    output logic        pwm_out
);

    import gpsdo_pkg::*;

    localparam logic [24:0]          PERIOD_25 = 25'(PERIOD);
    localparam logic [24:0]          HALF_25   = 25'(PERIOD / 2);
    localparam logic [AVG_SHIFT:0]   N_LAST    = (AVG_SHIFT+1)'((1 << AVG_SHIFT) - 1);
    localparam logic signed [41:0]   CENTER_42 = 42'(CENTER);
    localparam logic [15:0]          CENTER_16 = 16'(CENTER);

    state_t                 state;
    logic signed [27:0]     sum;
    logic [AVG_SHIFT:0]     n;
    logic signed [27:0]     avg;
    logic signed [31:0]     integ;

    logic [24:0]            cnt_ext;
    logic signed [24:0]     err;
    logic signed [27:0]     err_ext;
    logic signed [27:0]     sum_next;
    logic                   sample_ok;
    logic signed [32:0]     integ_sum;
    logic signed [41:0]     avg_x;
    logic signed [41:0]     kp_x;
    logic signed [41:0]     integ_x;
    logic signed [41:0]     acc;

    // Counts past the half period are the local edge leading GPS, so they
    // wrap to a negative error.
    always_comb begin
        cnt_ext   = {1'b0, phase_cnt};
        err       = (cnt_ext < HALF_25) ? cnt_ext : (cnt_ext - PERIOD_25);
        err_ext   = {{3{err[24]}}, err};
        sum_next  = sum + err_ext;
        sample_ok = (state == S_ACC) && GPS_Exist && phase_valid &&
                    (cnt_ext < PERIOD_25);
    end

    always_comb begin
        integ_sum = {integ[31], integ} + {{5{avg[27]}}, avg};
        avg_x     = {{14{avg[27]}}, avg};
        kp_x      = {{34{KP[7]}}, KP};
        integ_x   = {{10{integ[31]}}, integ};
        acc       = CENTER_42 + (avg_x * kp_x) + (integ_x >>> KI_SHIFT);
    end

    always_ff @(posedge CLK_Sys) begin
        if (!CLK_Rst) begin
            state      <= S_ACC;
            sum        <= '0;
            n          <= '0;
            avg        <= '0;
            integ      <= '0;
            PWM_Duty   <= CENTER_16;
            duty_valid <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            case (state)
                S_ACC: begin
                    // Holdover discards any partial average so recovery
                    // always starts from a full fresh set.
                    if (!GPS_Exist) begin
                        sum <= '0;
                        n   <= '0;
                    end else if (sample_ok) begin
                        sum <= sum_next;
                        n   <= n + 1'b1;
                        if (n == N_LAST)
                            state <= S_AVG;
                    end
                end
                S_AVG: begin
                    avg   <= sum >>> AVG_SHIFT;
                    sum   <= '0;
                    n     <= '0;
                    state <= S_INT;
                end
                S_INT: begin
                    integ <= sat32(integ_sum);
                    state <= S_OUT;
                end
                S_OUT: begin
                    PWM_Duty   <= clamp16(acc);
                    duty_valid <= 1'b1;
                    state      <= S_ACC;
                end
                default: state <= S_ACC;
            endcase
        end
    end

    pwm_gen #(
        .RESET_DUTY (CENTER_16)
    ) u_pwm_gen (
        .CLK_Sys (CLK_Sys),
        .CLK_Rst (CLK_Rst),
        .duty    (PWM_Duty),
        .pwm_out (pwm_out)
    );

endmodule
